alu_src_sequencer: RTL and testbench

//  Multi-cycle controller for the ALU source selector and ALU in the execute stage.
//  - Accepts one decoded operation class per start pulse.
//  - Sequences one or two ALU passes, driving the one-hot source selects
//    (const/imm_val/offset; all low = register file), the ALU enable and the

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_src_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_src_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU source sequencer: operation classes, FSM states,
// and the registered control-output bundle.
package alu_seq_pkg;

  localparam int unsigned ClassW = 3;
  localparam int unsigned ConstW = 3;

  typedef enum logic [2:0] {
    OpRr      = 3'd0,
    OpRc      = 3'd1,
    OpImm     = 3'd2,
    OpOff     = 3'd3,
    OpOffPost = 3'd4,
    OpPre     = 3'd5
  } op_class_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPass1 = 2'd1,
    StPass2 = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic illegal;
    logic const_sel;
    logic imm_val_sel;
    logic offset_sel;
    logic alu_en;
    logic reg_wr_en;
    logic psw_wr_en;
    logic addr_ld_en;
  } ctl_t;

  function automatic logic is_two_pass(input op_class_e c);
    return c == OpOffPost;
  endfunction

endpackage

// File: rtl/alu_src_sequencer.sv
// Execute-stage ALU source/enable sequencer: one or two ALU passes per start, then a done pulse.
// Optional ALU_SRC_SEQ_STALL_EN adds a stall input that freezes PASS states.
module alu_src_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned CLASS_W = ClassW,
  parameter int unsigned CONST_W = ConstW
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef ALU_SRC_SEQ_STALL_EN
  input  logic               stall,
`endif
  input  logic               start,
  input  logic [CLASS_W-1:0] op_class,
  input  logic [CONST_W-1:0] const_idx,
  input  logic               upd_psw,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               const_sel,
  output logic               imm_val_sel,
  output logic               offset_sel,
  output logic [CONST_W-1:0] const_code,
  output logic               alu_en,
  output logic               reg_wr_en,
  output logic               psw_wr_en,
  output logic               addr_ld_en
);

  state_e               state_q, state_d;
  logic [CLASS_W-1:0]   class_q, class_d;
  logic [CONST_W-1:0]   code_q, code_d;
  logic                 upd_q, upd_d;
  ctl_t                 ctl_q, ctl_d;
  logic                 stall_w;

`ifdef ALU_SRC_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    code_d  = code_q;
    upd_d   = upd_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          class_d = op_class;
          code_d  = const_idx;
          upd_d   = upd_psw;
          state_d = (op_class < CLASS_W'(6)) ? StPass1 : StDone;
        end
      end
      StPass1: begin
        if (!stall_w) begin
          state_d = is_two_pass(op_class_e'(class_q[2:0])) ? StPass2 : StDone;
        end
      end
      StPass2: begin
        if (!stall_w) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with the state itself.
  always_comb begin
    ctl_d      = '0;
    ctl_d.busy = (state_d != StIdle);
    case (state_d)
      StPass1: begin
        ctl_d.alu_en = 1'b1;
        case (op_class_e'(class_d[2:0]))
          OpRr: begin
            ctl_d.reg_wr_en = 1'b1;
            ctl_d.psw_wr_en = upd_d;
          end
          OpRc: begin
            ctl_d.const_sel = 1'b1;
            ctl_d.reg_wr_en = 1'b1;
            ctl_d.psw_wr_en = upd_d;
          end
          OpImm: begin
            ctl_d.imm_val_sel = 1'b1;
            ctl_d.reg_wr_en   = 1'b1;
            ctl_d.psw_wr_en   = upd_d;
          end
          OpOff, OpOffPost: begin
            ctl_d.offset_sel = 1'b1;
            ctl_d.addr_ld_en = 1'b1;
          end
          OpPre: begin
            ctl_d.const_sel  = 1'b1;
            ctl_d.reg_wr_en  = 1'b1;
            ctl_d.addr_ld_en = 1'b1;
          end
          default: ;
        endcase
      end
      StPass2: begin
        // Only post-modify uses a second pass: write back the incremented register.
        ctl_d.alu_en    = 1'b1;
        ctl_d.const_sel = 1'b1;
        ctl_d.reg_wr_en = 1'b1;
      end
      StDone: begin
        ctl_d.done    = 1'b1;
        ctl_d.illegal = !(class_d < CLASS_W'(6));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      class_q <= '0;
      code_q  <= '0;
      upd_q   <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      code_q  <= code_d;
      upd_q   <= upd_d;
      ctl_q   <= ctl_d;
    end
  end

  assign busy        = ctl_q.busy;
  assign done        = ctl_q.done;
  assign illegal     = ctl_q.illegal;
  assign const_sel   = ctl_q.const_sel;
  assign imm_val_sel = ctl_q.imm_val_sel;
  assign offset_sel  = ctl_q.offset_sel;
  assign const_code  = code_q;
  // A stalled pass keeps its selects but must not evaluate or write anything.
  assign alu_en      = ctl_q.alu_en & ~stall_w;
  assign reg_wr_en   = ctl_q.reg_wr_en & ~stall_w;
  assign psw_wr_en   = ctl_q.psw_wr_en & ~stall_w;
  assign addr_ld_en  = ctl_q.addr_ld_en & ~stall_w;

endmodule

// File: tb/tb_alu_src_sequencer.sv
// Self-checking bench for alu_src_sequencer: class table vectors through a scoreboard queue,
// plus hand sequences for start-hold, mid-sequence reset and (optionally) stall.
module tb_alu_src_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op_class = '0;
  logic [2:0] const_idx = '0;
  logic       upd_psw = 1'b0;
`ifdef ALU_SRC_SEQ_STALL_EN
  logic       stall = 1'b0;
`endif
  logic       busy, done, illegal, const_sel, imm_val_sel, offset_sel;
  logic [2:0] const_code;
  logic       alu_en, reg_wr_en, psw_wr_en, addr_ld_en;

  always #5 clk = ~clk;

  alu_src_sequencer #(
    .CLASS_W(3),
    .CONST_W(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ALU_SRC_SEQ_STALL_EN
    .stall      (stall),
`endif
    .start      (start),
    .op_class   (op_class),
    .const_idx  (const_idx),
    .upd_psw    (upd_psw),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .const_sel  (const_sel),
    .imm_val_sel(imm_val_sel),
    .offset_sel (offset_sel),
    .const_code (const_code),
    .alu_en     (alu_en),
    .reg_wr_en  (reg_wr_en),
    .psw_wr_en  (psw_wr_en),
    .addr_ld_en (addr_ld_en)
  );

  // {busy, done, illegal, const, imm, off, alu, reg, psw, addr, const_code[2:0]}
  logic [12:0] act;
  assign act = {busy, done, illegal, const_sel, imm_val_sel, offset_sel,
                alu_en, reg_wr_en, psw_wr_en, addr_ld_en, const_code};

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  // p = {const, imm, off, alu, reg, psw, addr}
  typedef struct {
    logic [2:0] cls;
    logic [2:0] idx;
    logic       upd;
    int         npass;
    logic [6:0] p1;
    logic [6:0] p2;
    logic       ill;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [12:0] pass_v(input logic [6:0] p, input logic [2:0] c);
    return {3'b100, p, c};
  endfunction

  function automatic logic [12:0] done_v(input logic ill, input logic [2:0] c);
    return {2'b11, ill, 7'b0000000, c};
  endfunction

  // const_code is only constrained while busy unless a full compare is requested.
  task automatic check(input string name, input logic [12:0] expv, input bit full);
    logic [12:0] mask;
    mask = (expv[12] || full) ? 13'h1FFF : 13'h1FF8;
    checks++;
    if ((act & mask) !== (expv & mask)) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic push_seq(input vec_t v);
    if (v.npass >= 1) exp_q.push_back(pass_v(v.p1, v.idx));
    if (v.npass == 2) exp_q.push_back(pass_v(v.p2, v.idx));
    exp_q.push_back(done_v(v.ill, v.idx));
    exp_q.push_back(13'h0);
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      check($sformatf("%s_t%0d", name, cyc), exp_q.pop_front(), 1'b0);
    end
  endtask

  task automatic launch(input logic [2:0] cls, input logic [2:0] idx, input logic upd);
    op_class  = cls;
    const_idx = idx;
    upd_psw   = upd;
    start     = 1'b1;
  endtask

  initial begin
    int ndone;
    vecs[0] = '{cls: 3'd0, idx: 3'd5, upd: 1'b1, npass: 1, p1: 7'b000_1110, p2: 7'b0, ill: 1'b0};
    vecs[1] = '{cls: 3'd1, idx: 3'd3, upd: 1'b1, npass: 1, p1: 7'b100_1110, p2: 7'b0, ill: 1'b0};
    vecs[2] = '{cls: 3'd1, idx: 3'd6, upd: 1'b0, npass: 1, p1: 7'b100_1100, p2: 7'b0, ill: 1'b0};
    vecs[3] = '{cls: 3'd2, idx: 3'd1, upd: 1'b1, npass: 1, p1: 7'b010_1110, p2: 7'b0, ill: 1'b0};
    vecs[4] = '{cls: 3'd3, idx: 3'd2, upd: 1'b1, npass: 1, p1: 7'b001_1001, p2: 7'b0, ill: 1'b0};
    vecs[5] = '{cls: 3'd4, idx: 3'd4, upd: 1'b1, npass: 2, p1: 7'b001_1001, p2: 7'b100_1100,
                ill: 1'b0};
    vecs[6] = '{cls: 3'd5, idx: 3'd7, upd: 1'b1, npass: 1, p1: 7'b100_1101, p2: 7'b0, ill: 1'b0};
    vecs[7] = '{cls: 3'd6, idx: 3'd2, upd: 1'b1, npass: 0, p1: 7'b0, p2: 7'b0, ill: 1'b1};
    vecs[8] = '{cls: 3'd7, idx: 3'd1, upd: 1'b1, npass: 0, p1: 7'b0, p2: 7'b0, ill: 1'b1};
    vecs[9] = '{cls: 3'd0, idx: 3'd0, upd: 1'b0, npass: 1, p1: 7'b000_1100, p2: 7'b0, ill: 1'b0};

    #12;
    check("reset_state", 13'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", 13'h0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].cls, vecs[i].idx, vecs[i].upd);
      push_seq(vecs[i]);
      drain($sformatf("vec%0d_cls%0d", i, vecs[i].cls));
    end

    // start held for four cycles: one sequence, then a second accepted in the IDLE cycle t3
    launch(3'd0, 3'd5, 1'b1);
    exp_q.push_back(pass_v(7'b000_1110, 3'd5));
    exp_q.push_back(done_v(1'b0, 3'd5));
    exp_q.push_back(13'h0);
    exp_q.push_back(pass_v(7'b000_1110, 3'd5));
    exp_q.push_back(done_v(1'b0, 3'd5));
    exp_q.push_back(13'h0);
    ndone = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      check($sformatf("hold_start_t%0d", k), exp_q.pop_front(), 1'b0);
      start = (k < 4);
    end
    checks++;
    if (ndone != 2) begin
      errors++;
      $display("FAIL hold_start_done_count: got %0d expected 2", ndone);
    end

    // Reset during PASS2 of post-modify aborts with no done pulse
    launch(3'd4, 3'd4, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rst_abort_pass1", pass_v(7'b001_1001, 3'd4), 1'b0);
    @(posedge clk);
    #1;
    check("rst_abort_pass2", pass_v(7'b100_1100, 3'd4), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_abort_async", 13'h0, 1'b1);
    @(posedge clk);
    #1;
    check("rst_abort_edge", 13'h0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_abort_idle", 13'h0, 1'b1);

`ifdef ALU_SRC_SEQ_STALL_EN
    // IMM stalled at t1..t2: selects hold, enables gated; completes at t3, done at t4
    launch(3'd2, 3'd2, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      stall = (k <= 2);
      #1;
      case (k)
        1, 2:    check($sformatf("stall_t%0d", k), pass_v(7'b010_0000, 3'd2), 1'b0);
        3:       check("stall_t3", pass_v(7'b010_1110, 3'd2), 1'b0);
        4:       check("stall_t4", done_v(1'b0, 3'd2), 1'b0);
        default: check("stall_t5", 13'h0, 1'b0);
      endcase
    end
    stall = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
